// File: rtl/rom_arb_pkg.sv
// Shared encodings for the firmware ROM port arbiter: FSM states, grant bit
// positions and counter widths.
package rom_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam int GNT_I_BIT = 0;
    localparam int GNT_D_BIT = 1;

    localparam int STREAK_W = 8;
    localparam int TMO_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GNT_I = ST_GNT_I,
        GNT_D = ST_GNT_D
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Clear/enable counter that flags expiry once LIMIT-1 enabled cycles have elapsed
// since the last clear; holds at the expiry value until cleared.
module arb_timeout_ctr
    import rom_arb_pkg::*;
#(
    parameter int CNT_W = TMO_W,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/rom_port_arbiter.sv
// Registered arbiter sharing the single-ported firmware ROM between the CPU ibus
// and the dbus ROM window, with grant locking, bounded dbus wait and ack timeout.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int MAX_IBURST = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cyc,
    input  logic              i_stb,
    output logic              i_ack,
    output logic              i_err,
    output logic [DATA_W-1:0] i_dat,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_stb,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_dat,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_stb,
    input  logic [DATA_W-1:0] rom_dat,
    input  logic              rom_ack,
    output logic [1:0]        grant,
    output logic              timeout_evt
);

    localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(MAX_IBURST);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_nxt;

    logic w_ireq;
    logic w_dreq;
    logic w_own_req;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_tmo_expire;

    assign w_ireq = i_cyc & i_stb;
    assign w_dreq = d_stb;

    // Read data is broadcast; only the owner's ack qualifies it.
    assign i_dat = rom_dat;
    assign d_dat = rom_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Every grant is preceded by at least one IDLE cycle, so clearing in IDLE
    // gives a fresh count on each grant entry.
    assign w_tmo_clr = (r_state == IDLE);
    assign w_tmo_en  = (r_state != IDLE) && !rom_ack;

    arb_timeout_ctr #(
        .CNT_W (TMO_W),
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        w_own_req    = 1'b0;
        grant        = '0;
        rom_stb      = 1'b0;
        rom_addr     = '0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        i_err        = 1'b0;
        d_err        = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A late rom_ack here is deliberately ignored.
                if (w_dreq && (!w_ireq || (r_streak == BURST_MAX))) begin
                    w_state_nxt  = GNT_D;
                    w_streak_nxt = '0;
                end else if (w_ireq) begin
                    w_state_nxt = GNT_I;
                    if (w_dreq && (r_streak != BURST_MAX)) begin
                        w_streak_nxt = r_streak + 1'b1;
                    end
                end
                if (!w_dreq) begin
                    w_streak_nxt = '0;
                end
            end
            GNT_I: begin
                w_own_req        = w_ireq;
                grant[GNT_I_BIT] = 1'b1;
                rom_stb          = 1'b1;
                rom_addr         = i_addr;
                i_ack            = w_own_req & rom_ack;
                i_err            = w_own_req & ~rom_ack & w_tmo_expire;
            end
            GNT_D: begin
                w_own_req        = w_dreq;
                grant[GNT_D_BIT] = 1'b1;
                rom_stb          = 1'b1;
                rom_addr         = d_addr;
                d_ack            = w_own_req & rom_ack;
                d_err            = w_own_req & ~rom_ack & w_tmo_expire;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort, ack and timeout all release the ROM back to IDLE.
        if ((r_state == GNT_I) || (r_state == GNT_D)) begin
            if (!w_own_req || rom_ack || w_tmo_expire) begin
                w_state_nxt = IDLE;
            end
        end
    end

    assign timeout_evt = i_err | d_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: scripted vectors, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_rom_port_arbiter;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int MAX_IBURST = 4;
    localparam int TIMEOUT    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] i_addr, d_addr, rom_addr;
    logic              i_cyc, i_stb, d_stb;
    logic              i_ack, i_err, d_ack, d_err;
    logic [DATA_W-1:0] i_dat, d_dat;
    logic [DATA_W-1:0] rom_dat = '0;
    logic              rom_stb, rom_ack, timeout_evt;
    logic [1:0]        grant;

    logic r_ack = 1'b0;
    logic rom_en = 1'b1;
    logic rom_rand = 1'b0;
    logic spur = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    rom_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_IBURST (MAX_IBURST),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (i_addr),
        .i_cyc       (i_cyc),
        .i_stb       (i_stb),
        .i_ack       (i_ack),
        .i_err       (i_err),
        .i_dat       (i_dat),
        .d_addr      (d_addr),
        .d_stb       (d_stb),
        .d_ack       (d_ack),
        .d_err       (d_err),
        .d_dat       (d_dat),
        .rom_addr    (rom_addr),
        .rom_stb     (rom_stb),
        .rom_dat     (rom_dat),
        .rom_ack     (rom_ack),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [14:0] a);
        return (a == 15'h0040) ? 32'hDEADBEEF : (32'hA5000000 ^ {17'd0, a});
    endfunction

    // ROM model: acks the cycle after strobe, never two cycles back to back.
    always @(posedge clk) begin
        r_ack   <= rom_stb && !r_ack && rom_en && (!rom_rand || ($urandom_range(3) != 0));
        rom_dat <= romf(rom_addr);
    end
    assign rom_ack = r_ack | spur;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       ic;
        logic       st;
        logic       ds;
        logic       sp;
        logic [1:0] g;
        logic       stb;
        logic       ia;
        logic       da;
    } vec_t;

    vec_t tbl [17];

    logic [1:0] seq [16];
    int got, first_c, last_c;

    task automatic collect(input int n, input int budget);
        got = 0;
        first_c = -1;
        last_c = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            #2;
            if (i_ack || d_ack) begin
                seq[got] = {d_ack, i_ack};
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            step();
        end
    endtask

    // Reference model state: current owner (0 none, 1 ibus, 2 dbus), ibus
    // grants given while dbus waited, and grant cycles already spent.
    int m_owner, m_next, m_waits, m_age;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcnt, err_at, evt_n, acks, ierr_seen;
        int seen;
        logic ireq, dreq, oreq, done;
        logic [1:0] e_grant;
        logic e_stb, e_iack, e_dack, e_ierr, e_derr;
        logic [ADDR_W-1:0] e_addr;

        tbl[0]  = 11'b1100_00_000;
        tbl[1]  = 11'b1100_01_100;
        tbl[2]  = 11'b1100_01_110;
        tbl[3]  = 11'b0000_00_000;
        tbl[4]  = 11'b0010_00_000;
        tbl[5]  = 11'b0010_10_100;
        tbl[6]  = 11'b0010_10_101;
        tbl[7]  = 11'b0000_00_000;
        tbl[8]  = 11'b1100_00_000;
        tbl[9]  = 11'b1100_01_100;
        tbl[10] = 11'b1000_01_100;
        tbl[11] = 11'b0010_00_000;
        tbl[12] = 11'b0010_10_100;
        tbl[13] = 11'b0010_10_101;
        tbl[14] = 11'b0001_00_000;
        tbl[15] = 11'b0001_00_000;
        tbl[16] = 11'b0000_00_000;

        i_cyc = 1'b0; i_stb = 1'b0; d_stb = 1'b0;
        i_addr = 15'h0040; d_addr = 15'h0123;

        // Reset values, with requests asserted while reset is held.
        step();
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_stb", rom_stb, 1'b0);
        chk("rst_addr", rom_addr, 15'h0);
        chk("rst_acks", {i_ack, d_ack, i_err, d_err, timeout_evt}, 5'b0);
        chk("rst_idat", i_dat, rom_dat);
        chk("rst_ddat", d_dat, rom_dat);
        step();
        i_cyc = 1'b1; i_stb = 1'b1; d_stb = 1'b1;
        #2;
        chk("rst_hold_grant", grant, 2'b00);
        chk("rst_hold_stb", rom_stb, 1'b0);
        step();
        i_cyc = 1'b0; i_stb = 1'b0; d_stb = 1'b0;
        rst_n = 1'b1;

        // Scripted vectors: fetch, dbus read, abort on ack, spurious ack.
        for (int k = 0; k < 17; k++) begin
            {i_cyc, i_stb, d_stb, spur} = {tbl[k].ic, tbl[k].st, tbl[k].ds, tbl[k].sp};
            #2;
            chk($sformatf("vec%0d_grant", k), grant, tbl[k].g);
            chk($sformatf("vec%0d_stb", k), rom_stb, tbl[k].stb);
            chk($sformatf("vec%0d_ack", k), {i_ack, d_ack}, {tbl[k].ia, tbl[k].da});
            chk($sformatf("vec%0d_err", k), {i_err, d_err, timeout_evt}, 3'b000);
            if (k == 2) chk("fetch_dat", i_dat, 32'hDEADBEEF);
            if (k == 6) chk("dread_dat", d_dat, romf(15'h0123));
            step();
        end
        {i_cyc, i_stb, d_stb, spur} = 4'b0000;
        step();

        // Both ports held continuously: dbus gets every fifth transfer.
        i_cyc = 1'b1; i_stb = 1'b1; d_stb = 1'b1;
        collect(10, 60);
        chk("arb_count", got, 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("arb_seq%0d", k), seq[k], (k == 4 || k == 9) ? 2'b10 : 2'b01);
        end
        chk("arb_spacing", last_c - first_c, 27);

        // Reset in the middle of an ibus streak restarts the streak from zero.
        collect(3, 20);
        chk("streak_pre", got, 3);
        step();
        #2;
        chk("streak_mid_grant", grant, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("streak_rst_grant", grant, 2'b00);
        step();
        rst_n = 1'b1;
        collect(5, 40);
        chk("streak_post_count", got, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("streak_post%0d", k), seq[k], (k == 4) ? 2'b10 : 2'b01);
        end
        i_cyc = 1'b0; i_stb = 1'b0; d_stb = 1'b0;
        step();
        step();

        // ROM never acks: dbus times out in its sixteenth grant cycle.
        rom_en = 1'b0;
        d_stb = 1'b1;
        gcnt = 0; err_at = -1; evt_n = 0; acks = 0; ierr_seen = 0;
        for (int c = 0; c < 40 && err_at < 0; c++) begin
            #2;
            if (grant == 2'b10) gcnt++;
            if (d_ack) acks++;
            if (timeout_evt) evt_n++;
            if (i_err) ierr_seen++;
            if (d_err) err_at = gcnt;
            step();
        end
        d_stb = 1'b0;
        #2;
        chk("tmo_cycles", err_at, TIMEOUT);
        chk("tmo_evt_count", evt_n, 1);
        chk("tmo_no_ack", acks, 0);
        chk("tmo_no_ierr", ierr_seen, 0);
        chk("tmo_idle_grant", grant, 2'b00);
        chk("tmo_evt_clear", {timeout_evt, d_err}, 2'b00);
        rom_en = 1'b1;
        step();

        // Reset during GNT_D with rom_ack present: ack is lost, outputs drop now.
        d_stb = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            #2;
            if (grant == 2'b10 && rom_ack) seen = 1;
            else step();
        end
        chk("rstd_reach", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rstd_grant", grant, 2'b00);
        chk("rstd_stb", rom_stb, 1'b0);
        chk("rstd_addr", rom_addr, 15'h0);
        chk("rstd_dack", d_ack, 1'b0);
        step();
        rst_n = 1'b1;
        #2;
        chk("rstd_c0_grant", grant, 2'b00);
        step();
        #2;
        chk("rstd_c1", {grant, rom_stb, d_ack}, 4'b1010);
        step();
        #2;
        chk("rstd_c2_ack", d_ack, 1'b1);
        chk("rstd_c2_dat", d_dat, romf(15'h0123));
        step();
        d_stb = 1'b0;
        step();

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_owner = 0; m_waits = 0; m_age = 0;
        rom_rand = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7) == 0) {i_cyc, i_stb, d_stb} = 3'($urandom);
            i_addr = 15'($urandom);
            d_addr = 15'($urandom);
            rom_en = ((k / 150) % 4) != 3;
            spur = ($urandom_range(15) == 0);
            #2;
            ireq = i_cyc && i_stb;
            dreq = d_stb;
            e_grant = 2'b00; e_stb = 1'b0; e_addr = '0;
            e_iack = 1'b0; e_dack = 1'b0; e_ierr = 1'b0; e_derr = 1'b0;
            if (m_owner == 0) begin
                if (dreq && (!ireq || m_waits == MAX_IBURST)) begin
                    m_next = 2;
                    m_waits = 0;
                end else if (ireq) begin
                    m_next = 1;
                    if (dreq && m_waits < MAX_IBURST) m_waits++;
                end else begin
                    m_next = 0;
                end
                if (!dreq) m_waits = 0;
                m_age = 0;
            end else begin
                oreq = (m_owner == 1) ? ireq : dreq;
                e_grant = (m_owner == 1) ? 2'b01 : 2'b10;
                e_stb = 1'b1;
                e_addr = (m_owner == 1) ? i_addr : d_addr;
                done = 1'b1;
                if (!oreq) begin
                    done = 1'b1;
                end else if (rom_ack) begin
                    if (m_owner == 1) e_iack = 1'b1;
                    else e_dack = 1'b1;
                end else if (m_age == TIMEOUT - 1) begin
                    if (m_owner == 1) e_ierr = 1'b1;
                    else e_derr = 1'b1;
                end else begin
                    done = 1'b0;
                end
                m_age++;
                m_next = done ? 0 : m_owner;
            end
            chk($sformatf("rnd%0d", k),
                {grant, rom_stb, rom_addr, i_ack, d_ack, i_err, d_err, timeout_evt, i_dat, d_dat},
                {e_grant, e_stb, e_addr, e_iack, e_dack, e_ierr, e_derr, e_ierr | e_derr, rom_dat, rom_dat});
            m_owner = m_next;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
